// File: rtl/counter_sequencer.sv
// ============================================================================
// counter_sequencer - run/stop FSM and count register for the up/down counter
// Optional COUNTER_SEQ_PAUSE_EN adds a pause input that freezes counting.
// Revision: 1.0
// ============================================================================
`default_nettype none

module counter_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
`ifdef COUNTER_SEQ_PAUSE_EN
  input  logic             pause,
`endif
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo_lim,
  input  logic [WIDTH-1:0] hi_lim,
  output logic [WIDTH-1:0] counts,
  output logic             dir,
  output logic             running,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] M_UP      = 2'd0;
  localparam logic [1:0] M_DOWN    = 2'd1;
  localparam logic [1:0] M_BOUNCE  = 2'd2;
  localparam logic [1:0] M_ONESHOT = 2'd3;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state_q,  state_d;
  logic [1:0]       mode_q,   mode_d;
  logic [WIDTH-1:0] lo_q,     lo_d;
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic [WIDTH-1:0] counts_q, counts_d;
  logic             dir_q,    dir_d;
  logic             count_en;

`ifdef COUNTER_SEQ_PAUSE_EN
  assign count_en = tick & ~pause;
`else
  assign count_en = tick;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mode_q   <= M_UP;
      lo_q     <= '0;
      hi_q     <= '0;
      counts_q <= '0;
      dir_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      counts_q <= counts_d;
      dir_q    <= dir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    counts_d = counts_q;
    dir_d    = dir_q;

    // stop takes priority over everything, including a same-cycle start
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start && (lo_lim <= hi_lim)) begin
            state_d  = S_RUN;
            mode_d   = mode;
            lo_d     = lo_lim;
            hi_d     = hi_lim;
            counts_d = (mode == M_DOWN) ? hi_lim : lo_lim;
            dir_d    = (mode != M_DOWN);
          end
        end
        S_RUN: begin
          if (count_en) begin
            case (mode_q)
              M_UP:    counts_d = (counts_q == hi_q) ? lo_q : counts_q + ONE;
              M_DOWN:  counts_d = (counts_q == lo_q) ? hi_q : counts_q - ONE;
              M_BOUNCE: begin
                // a degenerate range has nowhere to move, so it simply holds
                if (lo_q != hi_q) begin
                  if (dir_q && (counts_q == hi_q)) begin
                    dir_d    = 1'b0;
                    counts_d = hi_q - ONE;
                  end else if (!dir_q && (counts_q == lo_q)) begin
                    dir_d    = 1'b1;
                    counts_d = lo_q + ONE;
                  end else begin
                    counts_d = dir_q ? counts_q + ONE : counts_q - ONE;
                  end
                end
              end
              M_ONESHOT: begin
                if (counts_q == hi_q) begin
                  state_d = S_DONE;
                end else begin
                  counts_d = counts_q + ONE;
                end
              end
              default: counts_d = counts_q;
            endcase
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    counts  = counts_q;
    dir     = dir_q;
    running = (state_q == S_RUN);
    done    = (state_q == S_DONE);
  end

endmodule

`default_nettype wire
